// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - run controller for a programmable serial sequence detector
// Optional feature macro: SEQDET_OVERLAP_EN (overlapping match detection).
module seq_det_sched #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               din_valid,
    input  logic               din,
    output logic               hit,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [MAX_LEN-1:0] win_q, win_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] win_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               is_match;

    assign cfg_ready = (state_q == IDLE) || (state_q == DONE);

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // The length register resets to zero, which still has to behave as a 1-bit pattern.
    assign len_eff = (len_q == '0) ? LEN_W'(1) : len_q;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_eff));
        end
    end

    assign win_shift = {win_q[MAX_LEN-2:0], din};
    assign fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign is_match  = (fill_inc >= len_eff) &&
                       ((win_shift & len_mask) == (pattern_q & len_mask));

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        target_d  = target_q;
        win_d     = win_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        hit_d     = 1'b0;

        if (cfg_valid && cfg_ready) begin
            pattern_d = cfg_pattern;
            len_d     = len_clamped;
            target_d  = cfg_target;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    win_d   = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Stop outranks a bit completing on the same edge.
                if (stop) begin
                    state_d = IDLE;
                end else if (din_valid) begin
                    win_d  = win_shift;
                    fill_d = fill_inc;
                    if (is_match) begin
                        hit_d = 1'b1;
                        cnt_d = cnt_inc;
`ifdef SEQDET_OVERLAP_EN
                        fill_d = fill_inc;
`else
                        fill_d = '0;
`endif
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            target_q  <= '0;
            win_q     <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            target_q  <= target_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hit       = hit_q;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
